// File: rtl/cmp_slice_accumulator.sv
// cmp_slice_accumulator
// Consumes one {gt,lt,eq} slice relation per accepted beat, most-significant
// slice first, and reports the relation of the full-width operands. The
// first non-equal slice decides; later slices are consumed but ignored.
// Optional feature: define CMP_ACC_ERR_EN to flag illegal (non one-hot)
// slice codes on err and force y_out to 000 for the affected word.
module cmp_slice_accumulator #(
    parameter int NSLICES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] y_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] y_out,
    output logic       busy,
    output logic       err
);

    localparam int              CW       = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(NSLICES - 1);
    localparam logic [2:0]      REL_EQ   = 3'b001;
    localparam logic [2:0]      REL_LT   = 3'b010;
    localparam logic [2:0]      REL_GT   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    res;
    logic          decided;
    logic [2:0]    res_nxt;
    logic          decided_nxt;
    logic          accept;
    logic          clear;
    logic          last;
    logic [2:0]    slice_rel;
    logic          slice_ok;
    logic          word_err;

    // Priority decode of a slice code: gt wins over lt, anything else is eq.
    function automatic logic [2:0] decode_slice(input logic [2:0] y);
        if (y[2])
            return REL_GT;
        else if (y[1])
            return REL_LT;
        else
            return REL_EQ;
    endfunction

`ifdef CMP_ACC_ERR_EN
    // A slice code is legal only when it is exactly one-hot.
    function automatic logic slice_legal(input logic [2:0] y);
        return (y == REL_EQ) || (y == REL_LT) || (y == REL_GT);
    endfunction

    logic err_q;

    assign slice_ok  = slice_legal(y_in);
    assign slice_rel = y_in;
    assign word_err  = err_q | ~slice_ok;
    assign err       = err_q;

    // Sticky illegal-code flag, cleared when a new word begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (clear)
            err_q <= 1'b0;
        else if (accept && !slice_ok)
            err_q <= 1'b1;
    end
`else
    assign slice_ok  = 1'b1;
    assign slice_rel = decode_slice(y_in);
    assign word_err  = 1'b0;
    assign err       = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CNT_LAST);
    // A new word starts from IDLE, or straight out of HOLD on a handshake.
    assign clear  = start && ((state == IDLE) || ((state == HOLD) && out_ready));

    // Result including the slice currently presented; only the first
    // non-equal legal slice of a word can change it.
    always_comb begin
        res_nxt     = res;
        decided_nxt = decided;
        if (!decided && slice_ok && (slice_rel != REL_EQ)) begin
            res_nxt     = slice_rel;
            decided_nxt = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs, all decoded from registered state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last)
                    state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready)
                    state_nxt = start ? ACC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word accumulation: beat counter, running result and decided flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            res     <= REL_EQ;
            decided <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            res     <= REL_EQ;
            decided <= 1'b0;
        end else if (accept) begin
            cnt     <= last ? '0 : cnt + 1'b1;
            res     <= res_nxt;
            decided <= decided_nxt;
        end
    end

    // Final relation, loaded only on the last accept of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y_out <= 3'b000;
        else if (accept && last)
            y_out <= word_err ? 3'b000 : res_nxt;
    end

endmodule

// File: tb/tb_cmp_slice_accumulator.sv
// Directed bench for cmp_slice_accumulator (NSLICES=4). Expected values for
// the illegal-code word follow CMP_ACC_ERR_EN when it is defined.
module tb_cmp_slice_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] y_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] y_out;
    logic       busy;
    logic       err;

    int checks;
    int failures;

`ifdef CMP_ACC_ERR_EN
    localparam logic [2:0] BAD_WORD_Y = 3'b000;
    localparam logic [2:0] BAD_ERR    = 3'b001;
`else
    localparam logic [2:0] BAD_WORD_Y = 3'b010;
    localparam logic [2:0] BAD_ERR    = 3'b000;
`endif

    cmp_slice_accumulator #(.NSLICES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [2:0] y);
        in_valid = 1'b1;
        y_in     = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic ctrl(input string tag, input logic iv, input logic ov, input logic bz);
        chk({tag, "_in_ready"},  {2'b00, in_ready},  {2'b00, iv});
        chk({tag, "_out_valid"}, {2'b00, out_valid}, {2'b00, ov});
        chk({tag, "_busy"},      {2'b00, busy},      {2'b00, bz});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        y_in      = 3'b000;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        ctrl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_y_out", y_out, 3'b000);
        chk("rst_err", {2'b00, err}, 3'b000);
        rst_n = 1'b1;
        tick();
        ctrl("idle", 1'b0, 1'b0, 1'b0);

        // Word 1: 001,001,010,100 back-to-back, out_ready=1 -> 010
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ctrl("w1_acc", 1'b1, 1'b0, 1'b1);
        feed(3'b001);
        feed(3'b001);
        feed(3'b010);
        ctrl("w1_mid", 1'b1, 1'b0, 1'b1);
        feed(3'b100);
        ctrl("w1_hold", 1'b0, 1'b1, 1'b1);
        chk("w1_y_out", y_out, 3'b010);
        tick();
        ctrl("w1_idle", 1'b0, 1'b0, 1'b0);
        chk("w1_y_keep", y_out, 3'b010);

        // Word 2: all equal, held in HOLD with ignored start pulses
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        chk("w2_y_out", y_out, 3'b001);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            tick();
            ctrl("w2_hold", 1'b0, 1'b1, 1'b1);
            chk("w2_y_stable", y_out, 3'b001);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        ctrl("w2_idle", 1'b0, 1'b0, 1'b0);

        // Word 3 then back-to-back word 4 (100,010,001,001 -> 100)
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        feed(3'b010);
        chk("w3_y_out", y_out, 3'b010);
        out_ready = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        y_in = 3'b100;
        tick();
        in_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        ctrl("b2b_acc", 1'b1, 1'b0, 1'b1);
        chk("b2b_y_keep", y_out, 3'b010);
        feed(3'b100);
        feed(3'b010);
        feed(3'b001);
        feed(3'b001);
        ctrl("w4_hold", 1'b0, 1'b1, 1'b1);
        chk("w4_y_out", y_out, 3'b100);
        out_ready = 1'b1;
        tick();
        ctrl("w4_idle", 1'b0, 1'b0, 1'b0);

        // Word 5: gapped in_valid, garbage on idle beats -> 010
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(3'b001);
        y_in = 3'b100;
        tick();
        feed(3'b010);
        y_in = 3'b100;
        tick();
        feed(3'b100);
        y_in = 3'b100;
        tick();
        ctrl("w5_gap", 1'b1, 1'b0, 1'b1);
        feed(3'b001);
        ctrl("w5_hold", 1'b0, 1'b1, 1'b1);
        chk("w5_y_out", y_out, 3'b010);
        tick();

        // Word 6: reset after two slices, then new word 001,001,001,100
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(3'b100);
        feed(3'b100);
        rst_n = 1'b0;
        #1;
        ctrl("mid_rst", 1'b0, 1'b0, 1'b0);
        chk("mid_rst_y_out", y_out, 3'b000);
        chk("mid_rst_err", {2'b00, err}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
        ctrl("post_rst", 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        feed(3'b100);
        chk("w6_y_out", y_out, 3'b100);
        out_ready = 1'b0;

        // Word 7: illegal code 011 on the first beat
        tick();
        chk("w6_still_hold", {2'b00, out_valid}, 3'b001);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        feed(3'b011);
        chk("w7_err", {2'b00, err}, BAD_ERR);
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        chk("w7_y_out", y_out, BAD_WORD_Y);
        chk("w7_err_hold", {2'b00, err}, BAD_ERR);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("w8_err_clr", {2'b00, err}, 3'b000);
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        feed(3'b001);
        chk("w8_y_out", y_out, 3'b001);
        chk("w8_err", {2'b00, err}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
